// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared op codes, FSM states and limits for the calculator sequencer
package calc_pkg;

    localparam int MAX_RESULT_DEF = 9999;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTER_A,
        ST_ENTER_B,
        ST_COMPUTE,
        ST_SHOW,
        ST_ERROR
    } state_t;

endpackage

// File: rtl/calc_iter_alu.sv
// rtl/calc_iter_alu.sv - single-cycle add/sub and 16-step shift-add mul / restoring div
module calc_iter_alu
    import calc_pkg::*;
#(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           Reset,
    input  logic           start,
    input  logic           abort,
    input  logic [1:0]     op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] result,
    output logic           neg,
    output logic           dz
);

    logic [2*W-1:0] acc_q, x_q;
    logic [W-1:0]   y_q;
    logic [4:0]     cnt_q;
    logic           run_q;

    logic [2*W-1:0] cur_acc, cur_x, nxt_acc, nxt_x, rem_sh, b_ext;
    logic [W-1:0]   cur_y, nxt_y, diff;
    logic           iter_op, launch;

    assign iter_op = op[1];
    assign b_ext   = {{W{1'b0}}, b};
    assign dz      = start && (op == OP_DIV) && (b == '0);
    assign launch  = start && iter_op && !dz;

    // The start cycle already performs the first iteration, so 16 steps
    // finish in 16 cycles and the 17th cycle presents the result.
    always_comb begin
        cur_acc = start ? '0 : acc_q;
        cur_x   = start ? {{W{1'b0}}, a} : x_q;
        cur_y   = start ? ((op == OP_MUL) ? b : a) : y_q;
        rem_sh  = {cur_acc[2*W-2:0], cur_y[W-1]};
        nxt_acc = cur_acc;
        nxt_x   = cur_x;
        nxt_y   = cur_y;
        if (op == OP_MUL) begin
            nxt_acc = cur_acc + (cur_y[0] ? cur_x : '0);
            nxt_x   = cur_x << 1;
            nxt_y   = cur_y >> 1;
        end else if (rem_sh >= b_ext) begin
            nxt_acc = rem_sh - b_ext;
            nxt_y   = {cur_y[W-2:0], 1'b1};
        end else begin
            nxt_acc = rem_sh;
            nxt_y   = {cur_y[W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            acc_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (abort) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (launch) begin
            acc_q <= nxt_acc;
            x_q   <= nxt_x;
            y_q   <= nxt_y;
            cnt_q <= 5'd15;
            run_q <= 1'b1;
        end else if (run_q) begin
            if (cnt_q != 5'd0) begin
                acc_q <= nxt_acc;
                x_q   <= nxt_x;
                y_q   <= nxt_y;
                cnt_q <= cnt_q - 5'd1;
            end else begin
                run_q <= 1'b0;
            end
        end
    end

    assign done = (start && (!iter_op || dz)) || (run_q && (cnt_q == 5'd0));
    assign diff = (a >= b) ? (a - b) : (b - a);
    assign neg  = (op == OP_SUB) && (b > a);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = {{W{1'b0}}, a} + b_ext;
            OP_SUB:  result = {{W{1'b0}}, diff};
            OP_MUL:  result = acc_q;
            default: result = {{W{1'b0}}, y_q};
        endcase
    end

endmodule

// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - keypad sequencer: entry clearing, operand capture, compute and display select
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int W          = 16,
    parameter int MAX_RESULT = MAX_RESULT_DEF
) (
    input  logic         clk,
    input  logic         Reset,
    input  logic         digit_key,
    input  logic         op_key,
    input  logic [1:0]   op_code,
    input  logic         eq_key,
    input  logic         clr_key,
    input  logic [W-1:0] entry_value,
    output logic         entry_clr,
    output logic         disp_result,
    output logic [W-1:0] result,
    output logic         result_neg,
    output logic         busy,
    output logic         err
);

    localparam logic [2*W-1:0] MAX_W = (2*W)'(MAX_RESULT);

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, b_q, a_d, b_d, res_d;
    logic [1:0]     op_q, op_d;
    logic           start_q, start_d, entry_clr_d, neg_d, err_d;
    logic           k_clr, k_eq, k_op, k_dig;
    logic           alu_done, alu_neg, alu_dz, alu_bad;
    logic [2*W-1:0] alu_result;

    // Exactly one key wins per cycle: clr > eq > op > digit.
    assign k_clr = clr_key;
    assign k_eq  = eq_key && !clr_key;
    assign k_op  = op_key && !clr_key && !eq_key;
    assign k_dig = digit_key && !clr_key && !eq_key && !op_key;

    calc_iter_alu #(.W(W)) u_alu (
        .clk    (clk),
        .Reset  (Reset),
        .start  (start_q),
        .abort  (k_clr),
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .done   (alu_done),
        .result (alu_result),
        .neg    (alu_neg),
        .dz     (alu_dz)
    );

    assign alu_bad = alu_dz || (alu_result > MAX_W);

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (k_clr) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    if (k_dig) state_d = ST_ENTER_A;
                ST_ENTER_A: if (k_op) state_d = ST_ENTER_B;
                ST_ENTER_B: if (k_eq) state_d = ST_COMPUTE;
                ST_COMPUTE: if (alu_done) state_d = alu_bad ? ST_ERROR : ST_SHOW;
                ST_SHOW: begin
                    if (k_op)       state_d = ST_ENTER_B;
                    else if (k_dig) state_d = ST_ENTER_A;
                end
                ST_ERROR:   if (k_dig) state_d = ST_ENTER_A;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        res_d       = result;
        neg_d       = result_neg;
        err_d       = err;
        start_d     = 1'b0;
        entry_clr_d = 1'b0;
        if (k_clr) begin
            entry_clr_d = 1'b1;
            a_d         = '0;
            b_d         = '0;
            res_d       = '0;
            neg_d       = 1'b0;
            err_d       = 1'b0;
        end else begin
            case (state_q)
                ST_ENTER_A: if (k_op) begin
                    a_d         = entry_value;
                    op_d        = op_code;
                    entry_clr_d = 1'b1;
                end
                ST_ENTER_B: begin
                    if (k_eq) begin
                        b_d     = entry_value;
                        start_d = 1'b1;
                    end else if (k_op) begin
                        op_d = op_code;
                    end
                end
                ST_COMPUTE: if (alu_done) begin
                    if (alu_bad) begin
                        err_d = 1'b1;
                        res_d = '0;
                        neg_d = 1'b0;
                    end else begin
                        res_d = alu_result[W-1:0];
                        neg_d = alu_neg;
                    end
                end
                ST_SHOW: begin
                    if (k_op) begin
                        a_d         = result_neg ? '0 : result;
                        op_d        = op_code;
                        entry_clr_d = 1'b1;
                    end else if (k_dig) begin
                        entry_clr_d = 1'b1;
                        err_d       = 1'b0;
                    end
                end
                ST_ERROR: if (k_dig) begin
                    entry_clr_d = 1'b1;
                    err_d       = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= OP_ADD;
            start_q     <= 1'b0;
            entry_clr   <= 1'b0;
            disp_result <= 1'b0;
            result      <= '0;
            result_neg  <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            start_q     <= start_d;
            entry_clr   <= entry_clr_d;
            disp_result <= (state_d == ST_SHOW) || (state_d == ST_ERROR);
            result      <= res_d;
            result_neg  <= neg_d;
            busy        <= (state_d == ST_COMPUTE);
            err         <= err_d;
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// tb/tb_calc_sequencer.sv - directed scoreboard bench for calc_sequencer
module tb_calc_sequencer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         Reset = 1'b0;
    logic         digit_key = 1'b0;
    logic         op_key = 1'b0;
    logic [1:0]   op_code = 2'd0;
    logic         eq_key = 1'b0;
    logic         clr_key = 1'b0;
    logic [W-1:0] entry_value = '0;
    logic         entry_clr, disp_result, result_neg, busy, err;
    logic [W-1:0] result;

    calc_sequencer #(.W(W), .MAX_RESULT(9999)) dut (
        .clk         (clk),
        .Reset       (Reset),
        .digit_key   (digit_key),
        .op_key      (op_key),
        .op_code     (op_code),
        .eq_key      (eq_key),
        .clr_key     (clr_key),
        .entry_value (entry_value),
        .entry_clr   (entry_clr),
        .disp_result (disp_result),
        .result      (result),
        .result_neg  (result_neg),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int res;
        bit neg;
        bit err;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input int a, input int opc, input int b);
        exp_t e;
        e.res = 0;
        e.neg = 0;
        e.err = 0;
        e.cyc = (opc >= 2 && !(opc == 3 && b == 0)) ? 17 : 1;
        case (opc)
            0: e.res = a + b;
            1: begin
                e.res = (a >= b) ? a - b : b - a;
                e.neg = (b > a);
            end
            2: e.res = a * b;
            default: if (b == 0) e.err = 1; else e.res = a / b;
        endcase
        if (e.res > 9999) e.err = 1;
        if (e.err) begin
            e.res = 0;
            e.neg = 0;
        end
        return e;
    endfunction

    task automatic pulse_digit(input int v);
        entry_value = W'(v);
        digit_key = 1'b1;
        @(negedge clk);
        digit_key = 1'b0;
    endtask

    task automatic pulse_op(input int c);
        op_code = 2'(c);
        op_key = 1'b1;
        @(negedge clk);
        op_key = 1'b0;
    endtask

    task automatic pulse_eq();
        eq_key = 1'b1;
        @(negedge clk);
        eq_key = 1'b0;
    endtask

    task automatic pulse_clr(input string tag);
        clr_key = 1'b1;
        @(negedge clk);
        clr_key = 1'b0;
        chk({tag, " clr entry_clr"}, 32'(entry_clr), 1);
        chk({tag, " clr result"}, 32'(result), 0);
        chk({tag, " clr disp"}, 32'(disp_result), 0);
    endtask

    task automatic enter_a_op(input string tag, input int a, input int opc);
        pulse_digit(a);
        pulse_op(opc);
        chk({tag, " entry_clr pulse"}, 32'(entry_clr), 1);
        @(negedge clk);
        chk({tag, " entry_clr drop"}, 32'(entry_clr), 0);
    endtask

    task automatic run_eq(input string tag, input int a, input int opc, input int b);
        int   cnt;
        exp_t e;
        pulse_digit(b);
        exp_q.push_back(model(a, opc, b));
        pulse_eq();
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        e = exp_q.pop_front();
        chk({tag, " busy cycles"}, 32'(cnt), 32'(e.cyc));
        chk({tag, " result"}, 32'(result), 32'(e.res));
        chk({tag, " result_neg"}, 32'(result_neg), 32'(e.neg));
        chk({tag, " err"}, 32'(err), 32'(e.err));
        chk({tag, " disp_result"}, 32'(disp_result), 1);
    endtask

    initial begin
        #12;
        chk("reset entry_clr", 32'(entry_clr), 0);
        chk("reset disp", 32'(disp_result), 0);
        chk("reset result", 32'(result), 0);
        chk("reset neg", 32'(result_neg), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset err", 32'(err), 0);
        @(negedge clk);
        Reset = 1'b1;
        @(negedge clk);

        enter_a_op("add", 123, 0);
        run_eq("add", 123, 0, 456);
        pulse_clr("add");

        enter_a_op("sub", 5, 1);
        run_eq("sub", 5, 1, 9);
        pulse_op(0);
        chk("chain entry_clr", 32'(entry_clr), 1);
        run_eq("chain", 0, 0, 3);
        pulse_clr("chain");

        enter_a_op("mul", 25, 2);
        run_eq("mul", 25, 2, 40);
        pulse_op(3);
        run_eq("div", 1000, 3, 7);
        pulse_clr("div");

        enter_a_op("ovf", 999, 2);
        run_eq("ovf", 999, 2, 999);
        pulse_digit(4);
        chk("ovf digit entry_clr", 32'(entry_clr), 1);
        chk("ovf digit err", 32'(err), 0);
        chk("ovf digit disp", 32'(disp_result), 0);
        pulse_clr("ovf");

        enter_a_op("dz", 7, 3);
        run_eq("dz", 7, 3, 0);
        pulse_clr("dz");

        enter_a_op("clr_eq", 7, 3);
        pulse_digit(3);
        clr_key = 1'b1;
        eq_key = 1'b1;
        @(negedge clk);
        clr_key = 1'b0;
        eq_key = 1'b0;
        chk("clr_eq busy", 32'(busy), 0);
        chk("clr_eq entry_clr", 32'(entry_clr), 1);
        repeat (3) @(negedge clk);
        chk("clr_eq busy later", 32'(busy), 0);
        chk("clr_eq disp", 32'(disp_result), 0);
        pulse_op(0);
        chk("idle op ignored", 32'(entry_clr), 0);

        pulse_digit(100);
        pulse_op(3);
        pulse_digit(3);
        pulse_eq();
        chk("abort busy c1", 32'(busy), 1);
        repeat (4) @(negedge clk);
        chk("abort busy c5", 32'(busy), 1);
        pulse_clr("abort");
        chk("abort busy", 32'(busy), 0);
        repeat (20) @(negedge clk);
        chk("abort busy late", 32'(busy), 0);
        chk("abort result late", 32'(result), 0);
        chk("abort err late", 32'(err), 0);

        pulse_digit(12);
        pulse_op(2);
        pulse_digit(34);
        pulse_eq();
        repeat (3) @(negedge clk);
        #2 Reset = 1'b0;
        #1;
        chk("areset busy", 32'(busy), 0);
        chk("areset entry_clr", 32'(entry_clr), 0);
        chk("areset disp", 32'(disp_result), 0);
        chk("areset result", 32'(result), 0);
        chk("areset err", 32'(err), 0);
        @(negedge clk);
        Reset = 1'b1;
        @(negedge clk);

        enter_a_op("post", 50, 1);
        run_eq("post", 50, 1, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
